// File: rtl/sgmii_rate_adapt_if.sv
// Bundles the GMII client side and the PCS side of the SGMII rate adapter.
// The slave modport is the adapter's own view; master is the MAC/PCS side.
interface sgmii_rate_adapt_if #(
  parameter int unsigned DATA_W = 8
);
  logic [2:0]        Speed;
  logic [DATA_W-1:0] TxD;
  logic              TxDV;
  logic              TxER;
  logic              tx_ce;
  logic [DATA_W-1:0] pcs_TxD;
  logic              pcs_TxEN;
  logic              pcs_TxER;
  logic [DATA_W-1:0] pcs_RxD;
  logic              pcs_RxDV;
  logic              pcs_RxER;
  logic [DATA_W-1:0] RxD;
  logic              RxDV;
  logic              RxER;
  logic              rx_ce;

  modport slave (
    input  Speed, TxD, TxDV, TxER, pcs_RxD, pcs_RxDV, pcs_RxER,
    output tx_ce, pcs_TxD, pcs_TxEN, pcs_TxER, RxD, RxDV, RxER, rx_ce
  );

  modport master (
    output Speed, TxD, TxDV, TxER, pcs_RxD, pcs_RxDV, pcs_RxER,
    input  tx_ce, pcs_TxD, pcs_TxEN, pcs_TxER, RxD, RxDV, RxER, rx_ce
  );
endinterface

// File: rtl/sgmii_rate_adapt.sv
// SGMII rate adapter: byte replication on transmit, phase-realigned decimation on receive,
// all on one 125 MHz clock with clock-enable strobes instead of divided clocks.
module sgmii_rate_adapt #(
  parameter int unsigned REP_1000 = 1,
  parameter int unsigned REP_100  = 10,
  parameter int unsigned REP_10   = 100,
  parameter int unsigned DATA_W   = 8
) (
  input logic              clk_125M,
  input logic              rstn,
  sgmii_rate_adapt_if.slave ra
);

  localparam int unsigned MaxRepA = (REP_1000 > REP_100) ? REP_1000 : REP_100;
  localparam int unsigned MaxRep  = (MaxRepA > REP_10) ? MaxRepA : REP_10;
  localparam int unsigned CntW    = (MaxRep > 1) ? $clog2(MaxRep) : 1;

  logic [2:0]        speed_q;
  logic [CntW-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [CntW-1:0]   rep_last, rep_mid, phase;
  logic              dv_q;
  logic [DATA_W-1:0] txd_q, txd_d, rxd_q, rxd_d;
  logic              txen_q, txen_d, txer_q, txer_d;
  logic              rxdv_q, rxdv_d, rxer_q, rxer_d, rxce_q, rxce_d;
  logic              speed_chg, tx_ce, rise, sample;

  // Unlisted Speed codes fall back to gigabit.
  always_comb begin
    case (ra.Speed)
      3'b010: begin
        rep_last = CntW'(REP_100 - 1);
        rep_mid  = CntW'(REP_100 / 2);
      end
      3'b001: begin
        rep_last = CntW'(REP_10 - 1);
        rep_mid  = CntW'(REP_10 / 2);
      end
      default: begin
        rep_last = CntW'(REP_1000 - 1);
        rep_mid  = CntW'(REP_1000 / 2);
      end
    endcase
  end

  always_comb begin
    speed_chg = (ra.Speed != speed_q);
    tx_ce     = (tx_cnt_q == '0);
    tx_cnt_d  = (speed_chg || (tx_cnt_q == rep_last)) ? '0 : tx_cnt_q + 1'b1;
    txd_d     = txd_q;
    txen_d    = txen_q;
    txer_d    = txer_q;
    if (speed_chg) begin
      txd_d  = '0;
      txen_d = 1'b0;
      txer_d = 1'b0;
    end else if (tx_ce) begin
      txd_d  = ra.TxD;
      txen_d = ra.TxDV;
      txer_d = ra.TxER;
    end
  end

  // A frame start restarts the symbol phase so sampling lands mid-symbol.
  always_comb begin
    rise     = ra.pcs_RxDV & ~dv_q;
    phase    = rise ? '0 : rx_cnt_q;
    rx_cnt_d = (speed_chg || (phase == rep_last)) ? '0 : phase + 1'b1;
    sample   = !speed_chg && (phase == rep_mid);
    rxce_d   = sample;
    rxd_d    = rxd_q;
    rxdv_d   = rxdv_q;
    rxer_d   = rxer_q;
    if (speed_chg) begin
      rxdv_d = 1'b0;
      rxer_d = 1'b0;
    end else if (sample) begin
      rxd_d  = ra.pcs_RxD;
      rxdv_d = ra.pcs_RxDV;
      rxer_d = ra.pcs_RxER;
    end
  end

  always_ff @(posedge clk_125M or negedge rstn) begin
    if (!rstn) begin
      speed_q  <= 3'b100;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      dv_q     <= 1'b0;
      txd_q    <= '0;
      txen_q   <= 1'b0;
      txer_q   <= 1'b0;
      rxd_q    <= '0;
      rxdv_q   <= 1'b0;
      rxer_q   <= 1'b0;
      rxce_q   <= 1'b0;
    end else begin
      speed_q  <= ra.Speed;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      dv_q     <= ra.pcs_RxDV;
      txd_q    <= txd_d;
      txen_q   <= txen_d;
      txer_q   <= txer_d;
      rxd_q    <= rxd_d;
      rxdv_q   <= rxdv_d;
      rxer_q   <= rxer_d;
      rxce_q   <= rxce_d;
    end
  end

  assign ra.tx_ce    = tx_ce;
  assign ra.pcs_TxD  = txd_q;
  assign ra.pcs_TxEN = txen_q;
  assign ra.pcs_TxER = txer_q;
  assign ra.RxD      = rxd_q;
  assign ra.RxDV     = rxdv_q;
  assign ra.RxER     = rxer_q;
  assign ra.rx_ce    = rxce_q;

endmodule

// File: tb/tb_sgmii_rate_adapt.sv
// Directed bench for sgmii_rate_adapt at the default 1/10/100 replication factors.
module tb_sgmii_rate_adapt;

  logic clk_125M = 1'b0;
  logic rstn     = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  sgmii_rate_adapt_if #(.DATA_W(8)) ra ();

  sgmii_rate_adapt #(
    .REP_1000(1),
    .REP_100 (10),
    .REP_10  (100),
    .DATA_W  (8)
  ) dut (
    .clk_125M(clk_125M),
    .rstn    (rstn),
    .ra      (ra)
  );

  always #4 clk_125M = ~clk_125M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Outputs are checked and inputs changed on the falling edge.
  task automatic tick();
    @(negedge clk_125M);
  endtask

  task automatic drive_tx(input logic [7:0] d, input logic dv, input logic er);
    ra.TxD  = d;
    ra.TxDV = dv;
    ra.TxER = er;
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic dv, input logic er);
    ra.pcs_RxD  = d;
    ra.pcs_RxDV = dv;
    ra.pcs_RxER = er;
  endtask

  task automatic run_passthrough(input string tag);
    logic [7:0] pt [6];
    pt = '{8'h55, 8'hD5, 8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 7; i++) begin
      check({tag, "_txce"}, 32'(ra.tx_ce), 32'd1);
      if (i > 0) begin
        check({tag, "_txd"}, 32'(ra.pcs_TxD), 32'(pt[i-1]));
        check({tag, "_txen"}, 32'(ra.pcs_TxEN), 32'd1);
        check({tag, "_rxd"}, 32'(ra.RxD), 32'(pt[i-1]));
        check({tag, "_rxdv"}, 32'(ra.RxDV), 32'd1);
        check({tag, "_rxce"}, 32'(ra.rx_ce), 32'd1);
      end
      if (i < 6) begin
        drive_tx(pt[i], 1'b1, 1'b0);
        drive_rx(pt[i], 1'b1, 1'b0);
      end else begin
        drive_tx(8'h00, 1'b0, 1'b0);
        drive_rx(8'h00, 1'b0, 1'b0);
      end
      tick();
    end
  endtask

  initial begin
    logic [7:0] exp_b;
    logic [7:0] rx_b [3];
    int         en_cnt;
    int         ce_cnt;
    logic       exp_ce;

    rx_b     = '{8'h10, 8'h20, 8'h30};
    ra.Speed = 3'b100;
    drive_tx(8'h00, 1'b0, 1'b0);
    drive_rx(8'h00, 1'b0, 1'b0);

    // Reset state
    tick();
    tick();
    check("rst_txce", 32'(ra.tx_ce), 32'd1);
    check("rst_txd", 32'(ra.pcs_TxD), 32'd0);
    check("rst_txen", 32'(ra.pcs_TxEN), 32'd0);
    check("rst_rxdv", 32'(ra.RxDV), 32'd0);
    check("rst_rxce", 32'(ra.rx_ce), 32'd0);
    rstn = 1'b1;

    // 1000 Mb/s passthrough with loopback-style receive
    run_passthrough("pt1000");

    // 100 Mb/s transmit, 4-byte frame
    ra.Speed = 3'b010;
    tick();
    en_cnt = 0;
    for (int t = 0; t <= 50; t++) begin
      check("tx100_ce", 32'(ra.tx_ce), (t % 10 == 0) ? 32'd1 : 32'd0);
      if (t >= 1 && t <= 40) begin
        exp_b = 8'hA1 + 8'((t - 1) / 10);
        check("tx100_txd", 32'(ra.pcs_TxD), 32'(exp_b));
      end
      en_cnt += int'(ra.pcs_TxEN);
      if (t % 10 == 0) begin
        if (t < 40) drive_tx(8'hA1 + 8'(t / 10), 1'b1, 1'b0);
        else        drive_tx(8'h00, 1'b0, 1'b0);
      end
      tick();
    end
    check("tx100_en_cycles", 32'(en_cnt), 32'd40);

    // 10 Mb/s receive, frame starting off a symbol boundary
    ra.Speed = 3'b001;
    tick();
    ce_cnt = 0;
    for (int t = 0; t <= 400; t++) begin
      exp_ce = (t >= 88) && ((t - 88) % 100 == 0);
      check("rx10_ce", 32'(ra.rx_ce), 32'(exp_ce));
      ce_cnt += int'(ra.rx_ce);
      if (exp_ce && t < 388) begin
        check("rx10_rxd", 32'(ra.RxD), 32'(rx_b[(t - 88) / 100]));
        check("rx10_rxdv", 32'(ra.RxDV), 32'd1);
      end
      if (t == 388) check("rx10_dv_drop", 32'(ra.RxDV), 32'd0);
      if (t >= 37 && t < 337) drive_rx(rx_b[(t - 37) / 100], 1'b1, 1'b0);
      else                    drive_rx(8'h00, 1'b0, 1'b0);
      tick();
    end
    check("rx10_ce_count", 32'(ce_cnt), 32'd4);

    // Speed change 100 -> 1000 during byte 3
    ra.Speed = 3'b010;
    tick();
    for (int t = 0; t <= 25; t++) begin
      if (t % 10 == 0) drive_tx(8'hB0 + 8'(t / 10), 1'b1, 1'b0);
      drive_rx(8'hC0 + 8'(t / 10), 1'b1, 1'b0);
      if (t < 25) tick();
    end
    check("chg_pre_txd", 32'(ra.pcs_TxD), 32'hB2);
    check("chg_pre_txen", 32'(ra.pcs_TxEN), 32'd1);
    check("chg_pre_rxdv", 32'(ra.RxDV), 32'd1);
    check("chg_pre_rxd", 32'(ra.RxD), 32'hC1);
    ra.Speed = 3'b100;
    tick();
    check("chg_txen", 32'(ra.pcs_TxEN), 32'd0);
    check("chg_txd", 32'(ra.pcs_TxD), 32'd0);
    check("chg_rxdv", 32'(ra.RxDV), 32'd0);
    check("chg_rxce", 32'(ra.rx_ce), 32'd0);
    check("chg_rxd_kept", 32'(ra.RxD), 32'hC1);
    check("chg_txce", 32'(ra.tx_ce), 32'd1);
    drive_tx(8'h00, 1'b0, 1'b0);
    drive_rx(8'hC2, 1'b1, 1'b0);
    tick();
    for (int t = 27; t <= 30; t++) begin
      check("chg_post_txce", 32'(ra.tx_ce), 32'd1);
      check("chg_post_txen", 32'(ra.pcs_TxEN), 32'd0);
      check("chg_post_rxce", 32'(ra.rx_ce), 32'd1);
      check("chg_post_rxd", 32'(ra.RxD), 32'hC2);
      check("chg_post_rxdv", 32'(ra.RxDV), 32'd1);
      tick();
    end
    drive_rx(8'h00, 1'b0, 1'b0);
    tick();

    // Reset asserted mid-frame at 10 Mb/s
    ra.Speed = 3'b001;
    tick();
    drive_tx(8'h77, 1'b1, 1'b1);
    drive_rx(8'h66, 1'b1, 1'b1);
    for (int t = 0; t < 60; t++) tick();
    check("mid_txen", 32'(ra.pcs_TxEN), 32'd1);
    check("mid_txer", 32'(ra.pcs_TxER), 32'd1);
    check("mid_txd", 32'(ra.pcs_TxD), 32'h77);
    check("mid_rxd", 32'(ra.RxD), 32'h66);
    check("mid_rxdv", 32'(ra.RxDV), 32'd1);
    check("mid_rxer", 32'(ra.RxER), 32'd1);
    check("mid_txce", 32'(ra.tx_ce), 32'd0);
    #2 rstn = 1'b0;
    #1;
    check("arst_txd", 32'(ra.pcs_TxD), 32'd0);
    check("arst_txen", 32'(ra.pcs_TxEN), 32'd0);
    check("arst_txer", 32'(ra.pcs_TxER), 32'd0);
    check("arst_rxd", 32'(ra.RxD), 32'd0);
    check("arst_rxdv", 32'(ra.RxDV), 32'd0);
    check("arst_rxer", 32'(ra.RxER), 32'd0);
    check("arst_rxce", 32'(ra.rx_ce), 32'd0);
    check("arst_txce", 32'(ra.tx_ce), 32'd1);
    ra.Speed = 3'b100;
    drive_tx(8'h00, 1'b0, 1'b0);
    drive_rx(8'h00, 1'b0, 1'b0);
    tick();
    rstn = 1'b1;
    check("rel_txce0", 32'(ra.tx_ce), 32'd1);
    drive_tx(8'h3C, 1'b1, 1'b0);
    tick();
    check("rel_txd", 32'(ra.pcs_TxD), 32'h3C);
    check("rel_txen", 32'(ra.pcs_TxEN), 32'd1);
    check("rel_txce1", 32'(ra.tx_ce), 32'd1);
    drive_tx(8'h00, 1'b0, 1'b0);
    tick();

    // Unlisted Speed code behaves as gigabit
    ra.Speed = 3'b011;
    tick();
    run_passthrough("inv");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sgmii_rate_adapt.md
# sgmii_rate_adapt

Parametrised rate-adaptation stage between the GMII client interface and an SGMII PCS running on a fixed 125 MHz clock. On transmit it replicates each client byte REP times (1/10/100 for 1000/100/10 Mb/s) and paces the client with a clock-enable strobe. On receive it decimates the replicated PCS byte stream back to one byte per symbol period, re-aligning its sampling phase at each frame start. It sits between the MAC's GMII port and the serdes/PCS hard IP, replacing per-speed divided clocks with a single clock plus enables.

## Interface
- REP_1000, default 1: replication factor at 1000 Mb/s; must be ≥1.
- REP_100, default 10: replication factor at 100 Mb/s; must be ≥1.
- REP_10, default 100: replication factor at 10 Mb/s; must be ≥1.
- DATA_W, default 8: byte width.
- clk_125M  in  1  single clock, all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- Speed  in  3  3'b100 = 1000, 3'b010 = 100, 3'b001 = 10; any other code is treated as 1000.
- TxD  in  DATA_W  client transmit byte.
- TxDV  in  1  client transmit data valid.
- TxER  in  1  client transmit error.
- tx_ce  out  1  client advance strobe; inputs sampled on the edge where it is high.
- pcs_TxD  out  DATA_W  replicated byte to PCS.
- pcs_TxEN  out  1  replicated TxDV.
- pcs_TxER  out  1  replicated TxER.
- pcs_RxD  in  DATA_W  replicated receive byte from PCS.
- pcs_RxDV  in  1  PCS receive data valid.
- pcs_RxER  in  1  PCS receive error.
- RxD  out  DATA_W  decimated receive byte.
- RxDV  out  1  decimated data valid.
- RxER  out  1  decimated error.
- rx_ce  out  1  one-cycle strobe; marks a new RxD/RxDV/RxER value.

## Operation
- REP is selected from Speed. Counter width is clog2 of the largest REP, with a minimum of 1.
- **Transmit:**
  - tx_cnt counts 0..REP-1 and wraps to 0.
  - tx_ce = (tx_cnt == 0), decoded combinationally.
  - On an edge with tx_ce = 1, {TxD, TxDV, TxER} is captured into the hold register.
  - pcs_Tx* are the hold register outputs. Each byte is therefore driven for exactly REP consecutive cycles.
  - The client must hold its inputs stable from one tx_ce to the next.
- **Receive:**
  - rise = pcs_RxDV & ~dv_q, where dv_q is pcs_RxDV registered.
  - phase = rise ? 0 : rx_cnt.
  - rx_cnt next value = (phase == REP-1) ? 0 : phase+1.
  - Sample when phase == REP/2 (floor). On that edge, register pcs_Rx* into Rx* and set rx_ce = 1 for one cycle.
  - At REP = 1, every cycle is sampled.
  - A falling pcs_RxDV does not realign. The next sample naturally carries RxDV = 0.
- **Speed change:** detected as Speed differing from its registered copy. On the cycle after the change:
  - tx_cnt, rx_cnt = 0; hold register cleared (pcs_TxD = 0, pcs_TxEN = 0, pcs_TxER = 0).
  - RxDV, RxER = 0; RxD is retained; no rx_ce on that cycle.
  - Any frame in flight is truncated. No error is flagged; the MAC is responsible for dropping it.
  - New-rate operation starts at count 0.
- **Simultaneous events:** a speed change takes precedence over rise and over tx_ce capture on the same cycle.

## Timing
- Reset values:
  - pcs_TxD, pcs_TxEN, pcs_TxER, RxD, RxDV, RxER, rx_ce = 0.
  - tx_cnt, rx_cnt = 0, so tx_ce = 1 during reset.
  - dv_q = 0; the Speed register is loaded with 3'b100.
- Reset asserted mid-frame: outputs go to their reset values immediately (asynchronous). After release, the first tx_ce is on the first cycle.
- Transmit latency: a byte sampled on edge N appears on pcs_Tx* at N+1, for cycles N+1 .. N+REP.
- Receive latency: first byte of a frame, with pcs_RxDV rising at cycle C, is sampled at edge C+REP/2 and is visible on Rx* with rx_ce from cycle C+REP/2+1. Subsequent samples follow every REP cycles.
- rx_ce is never high on two consecutive cycles unless REP = 1.

## Test plan
- **1000 mode passthrough:** Speed = 3'b100, bytes 0x55, 0xD5, 0x01.. with TxDV = 1. Required: tx_ce constant 1; pcs_TxD follows TxD delayed 1 cycle. Loop pcs_Rx back: RxD equals the byte 1 cycle later, rx_ce constant 1.
- **100 mode transmit:** Speed = 3'b010, 4-byte frame 0xA1..0xA4. Required: tx_ce high every 10th cycle; each byte held on pcs_TxD for exactly 10 cycles; pcs_TxEN high for 40 cycles.
- **10 mode receive realign:** Speed = 3'b001, pcs_RxDV rising at cycle 37 (not a multiple of 100) with bytes each held 100 cycles. Required: first rx_ce at cycle 37+51 = 88 with RxD = first byte; then every 100 cycles; no duplicated or skipped bytes.
- **Speed change mid-frame:** switch 100 → 1000 during byte 3 of a frame. Required: next cycle pcs_TxEN = 0 and RxDV = 0; both counters restart at 0; tx_ce = 1 on every following cycle.
- **Reset mid-frame:** assert rstn low during a 10 Mb/s frame. Required: all outputs 0 immediately; after release, the first tx_ce is on cycle 0 and Speed is taken afresh.
- **Invalid Speed:** Speed = 3'b011. Required: behaves identically to 1000 mode.
